enc_sequencer: RTL

- Upstream stage of enc_processor.
- Accepts message beats over a valid/ready handshake and registers them onto for_data.
- Generates pro_phase (PRO_FIR/PRO_NOR/PRO_LAS/PRO_IDL) from a beat counter.
- After the last beat, reads the finished parity back from the processor's pro_data and presents it downstream as ENC_SYM_NUM-wide beats under a second valid/ready handshake.

---
 rtl/enc_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/enc_sequencer.sv
// enc_sequencer: front end of the RS encoder datapath.
// Registers message beats onto for_data with a matching pro_phase tag for enc_processor,
// then streams the finished parity (pro_data) downstream as ENC_SYM_NUM-symbol beats.
`timescale 1ns / 1ps

module enc_sequencer #(
  parameter int unsigned EGF_ORDER   = 8,
  parameter int unsigned ENC_SYM_NUM = 4,
  parameter int unsigned RS_MES_LEN  = 239,
  parameter int unsigned RS_PAR_LEN  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             mes_valid,
  output logic                             mes_ready,
  input  logic [ENC_SYM_NUM*EGF_ORDER-1:0] mes_data,
  output logic [1:0]                       pro_phase,
  output logic [ENC_SYM_NUM*EGF_ORDER-1:0] for_data,
  input  logic [RS_PAR_LEN*EGF_ORDER-1:0]  pro_data,
  output logic                             par_valid,
  input  logic                             par_ready,
  output logic [ENC_SYM_NUM*EGF_ORDER-1:0] par_data,
  output logic                             par_last
);

  // Beat counts are derived from the code geometry and cannot be overridden.
  localparam int unsigned MES_BEATS = (RS_MES_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
  localparam int unsigned PAR_BEATS = (RS_PAR_LEN + ENC_SYM_NUM - 1) / ENC_SYM_NUM;
  localparam int unsigned MES_CW    = (MES_BEATS > 1) ? $clog2(MES_BEATS) : 1;
  localparam int unsigned PAR_CW    = (PAR_BEATS > 1) ? $clog2(PAR_BEATS) : 1;

  // Phase codes shared with enc_processor.
  localparam logic [1:0] PRO_IDL = 2'b00;
  localparam logic [1:0] PRO_FIR = 2'b01;
  localparam logic [1:0] PRO_NOR = 2'b10;
  localparam logic [1:0] PRO_LAS = 2'b11;

  // Sequencer states.
  localparam logic [1:0] S_MES  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;

  // The first beat is only partially filled; a full first beat would make that lane rule
  // meaningless, so such a geometry is rejected at elaboration.
  if (RS_MES_LEN % ENC_SYM_NUM == 0) begin : g_bad_geometry
    $error("enc_sequencer: RS_MES_LEN must not be a multiple of ENC_SYM_NUM");
  end

  logic [1:0]        state_q, state_d;
  logic [MES_CW-1:0] mes_cnt_q, mes_cnt_d;
  logic [PAR_CW-1:0] par_cnt_q, par_cnt_d;
  logic              mes_fire;
  logic              par_fire;
  logic              mes_first;
  logic              mes_last;
  logic              par_final;
  int                par_idx;

  assign mes_ready = (state_q == S_MES);
  assign par_valid = (state_q == S_PAR);
  assign mes_fire  = mes_valid && mes_ready;
  assign par_fire  = par_valid && par_ready;
  assign mes_first = (mes_cnt_q == '0);
  assign mes_last  = (mes_cnt_q == MES_CW'(MES_BEATS - 1));
  assign par_final = (par_cnt_q == PAR_CW'(PAR_BEATS - 1));
  assign par_last  = par_valid && par_final;

  // Next-state and counter update for the message / wait / parity sequence.
  always_comb begin
    state_d   = state_q;
    mes_cnt_d = mes_cnt_q;
    par_cnt_d = par_cnt_q;
    unique case (state_q)
      S_MES: begin
        if (mes_fire) begin
          if (mes_last) begin
            mes_cnt_d = '0;
            state_d   = S_WAIT;
          end else begin
            mes_cnt_d = mes_cnt_q + MES_CW'(1);
          end
        end
      end
      // One cycle for the processor to absorb the LAS beat before parity is read.
      S_WAIT: begin
        state_d = S_PAR;
      end
      S_PAR: begin
        if (par_fire) begin
          if (par_final) begin
            par_cnt_d = '0;
            state_d   = S_MES;
          end else begin
            par_cnt_d = par_cnt_q + PAR_CW'(1);
          end
        end
      end
      default: begin
        state_d   = S_MES;
        mes_cnt_d = '0;
        par_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any codeword in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_MES;
      mes_cnt_q <= '0;
      par_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mes_cnt_q <= mes_cnt_d;
      par_cnt_q <= par_cnt_d;
    end
  end

  // Forward accepted beats with their position tag; idle edges tag IDL and hold the data,
  // which also leaves LAS on pro_phase for exactly the S_WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pro_phase <= PRO_IDL;
      for_data  <= '0;
    end else if (mes_fire) begin
      for_data <= mes_data;
      if (mes_first) begin
        pro_phase <= PRO_FIR;
      end else if (mes_last) begin
        pro_phase <= PRO_LAS;
      end else begin
        pro_phase <= PRO_NOR;
      end
    end else begin
      pro_phase <= PRO_IDL;
    end
  end

  // Parity beat k, lane l carries symbol RS_PAR_LEN - ENC_SYM_NUM*k - (ENC_SYM_NUM - l),
  // highest coefficient first; positions below zero are zero fill.
  always_comb begin
    par_data = '0;
    par_idx  = 0;
    for (int l = 0; l < int'(ENC_SYM_NUM); l++) begin
      par_idx = int'(RS_PAR_LEN) - int'(ENC_SYM_NUM) * int'(par_cnt_q) - (int'(ENC_SYM_NUM) - l);
      if (par_idx >= 0) begin
        par_data[l*EGF_ORDER +: EGF_ORDER] = pro_data[par_idx*EGF_ORDER +: EGF_ORDER];
      end
    end
  end

endmodule
